// File: rtl/gvt_reducer_pkg.sv
// gvt_reducer_pkg: shared virtual-time type, block constants and compare helpers.
package gvt_reducer_pkg;
  localparam int N_TILES = 8;
  localparam int TS_WIDTH = 32;
  localparam int TB_WIDTH = 32;
  localparam int LOG_GVT_PERIOD = 5;
  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [TB_WIDTH-1:0] tb;
  } vt_t;
  function automatic logic vt_lt(vt_t a, vt_t b);
    return {a.ts, a.tb} < {b.ts, b.tb};
  endfunction
  function automatic vt_t vt_min(vt_t a, vt_t b);
    return vt_lt(b, a) ? b : a;
  endfunction
endpackage

// File: rtl/gvt_reducer_min_tree_stage.sv
// min_tree_stage: one registered level of pairwise virtual-time minimum with a valid bit.
module min_tree_stage
  import gvt_reducer_pkg::*;
#(
  parameter int N_OUT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  vt_t  [2*N_OUT-1:0]     d_i,
  input  logic                   v_i,
  output vt_t  [N_OUT-1:0]       q_o,
  output logic                   v_o
);
  vt_t [N_OUT-1:0] q_q;
  logic v_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      q_q <= '1;
    end else begin
      v_q <= v_i;
      for (int i = 0; i < N_OUT; i++) q_q[i] <= vt_min(d_i[2*i], d_i[2*i+1]);
    end
  end
  assign q_o = q_q;
  assign v_o = v_q;
endmodule

// File: rtl/gvt_reducer.sv
// gvt_reducer: periodic snapshot of tile LVTs reduced to a global virtual time by a pipelined min tree.
// Build option GVT_MONOTONIC_CHECK_EN rejects GVT regressions and raises a sticky gvt_err.
module gvt_reducer #(
  parameter int N_TILES = gvt_reducer_pkg::N_TILES,
  parameter int LOG_GVT_PERIOD = gvt_reducer_pkg::LOG_GVT_PERIOD
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         pause,
  input  logic [N_TILES*gvt_reducer_pkg::TS_WIDTH-1:0] lvt_ts,
  input  logic [N_TILES*gvt_reducer_pkg::TB_WIDTH-1:0] lvt_tb,
  input  logic [N_TILES-1:0]                           lvt_valid,
  output logic [gvt_reducer_pkg::TS_WIDTH-1:0]         gvt_ts,
  output logic [gvt_reducer_pkg::TB_WIDTH-1:0]         gvt_tb,
  output logic                                         gvt_valid,
  output logic                                         gvt_err,
  output logic [15:0]                                  skipped_periods
);
  import gvt_reducer_pkg::*;
  localparam int D = $clog2(N_TILES);
  localparam int NP = 1 << D;
  logic [LOG_GVT_PERIOD-1:0] cnt_q, cnt_d;
  logic [15:0] skip_q, skip_d;
  vt_t [NP-1:0] slot, snap_q, snap_d;
  vt_t [D:0][NP-1:0] lvl;
  logic [D:0] lvl_v;
  logic snap_v_q, snap_v_d, wrap, all_valid, load;
  vt_t gvt_q, gvt_d;
  for (genvar i = 0; i < NP; i++) begin : g_slot
    if (i < N_TILES) begin : g_tile
      assign slot[i] = {lvt_ts[i*TS_WIDTH +: TS_WIDTH], lvt_tb[i*TB_WIDTH +: TB_WIDTH]};
    end else begin : g_pad
      assign slot[i] = '1;
    end
  end
  assign lvl[0] = snap_q;
  assign lvl_v[0] = snap_v_q;
  for (genvar l = 0; l < D; l++) begin : g_lvl
    min_tree_stage #(.N_OUT(NP >> (l + 1))) u_stage (
      .clk (clk),
      .rst (rst),
      .d_i (lvl[l][(NP>>l)-1:0]),
      .v_i (lvl_v[l]),
      .q_o (lvl[l+1][(NP>>(l+1))-1:0]),
      .v_o (lvl_v[l+1])
    );
    assign lvl[l+1][NP-1:(NP>>(l+1))] = '1;
  end
  // Commit is combinational on the last tree level so the pulse lands D+1 cycles after the snapshot.
`ifdef GVT_MONOTONIC_CHECK_EN
  logic err_q, err_d;
  always_comb begin
    load = lvl_v[D] && !vt_lt(lvl[D][0], gvt_q);
    err_d = err_q || (lvl_v[D] && vt_lt(lvl[D][0], gvt_q));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign gvt_err = err_q;
`else
  assign load = lvl_v[D];
  assign gvt_err = 1'b0;
`endif
  always_comb begin
    all_valid = &lvt_valid;
    wrap = !pause && (cnt_q == '1);
    cnt_d = pause ? cnt_q : cnt_q + 1'b1;
    snap_v_d = wrap && all_valid;
    snap_d = snap_v_d ? slot : snap_q;
    skip_d = (wrap && !all_valid && skip_q != 16'hFFFF) ? skip_q + 16'd1 : skip_q;
    gvt_d = load ? lvl[D][0] : gvt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      skip_q <= '0;
      snap_v_q <= 1'b0;
      snap_q <= '1;
      gvt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      skip_q <= skip_d;
      snap_v_q <= snap_v_d;
      snap_q <= snap_d;
      gvt_q <= gvt_d;
    end
  end
  assign gvt_ts = gvt_d.ts;
  assign gvt_tb = gvt_d.tb;
  assign gvt_valid = load;
  assign skipped_periods = skip_q;
endmodule
